fir_param_core: RTL and testbench

//  Parametrised successor FIR engine: taps and delay line held in internal registers, not external BRAM.

---
 rtl/fir_param_core.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fir_param_core.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_param_core.sv
// fir_param_core: register-based FIR engine with a single shared MAC.
// Coefficients and the delay line live in flops; AXI-Lite configures, AXI-Stream moves samples.
// Each output costs tap_num+2 cycles: accept sample, tap_num MAC steps, present result.
// Optional feature macro: FIR_SAT_EN selects saturating output reduction (default: wrap).
module fir_param_core #(
    parameter int pADDR_WIDTH = 12,
    parameter int DATA_W      = 32,
    parameter int COEF_W      = 32,
    parameter int MAX_TAPS    = 16,
    parameter int OUT_SHIFT   = 0
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst_n,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [pADDR_WIDTH-1:0]   awaddr,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [31:0]              wdata,
    input  logic                     arvalid,
    output logic                     arready,
    input  logic [pADDR_WIDTH-1:0]   araddr,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [31:0]              rdata,
    input  logic                     ss_tvalid,
    output logic                     ss_tready,
    input  logic signed [DATA_W-1:0] ss_tdata,
    input  logic                     ss_tlast,
    output logic                     sm_tvalid,
    input  logic                     sm_tready,
    output logic signed [DATA_W-1:0] sm_tdata,
    output logic                     sm_tlast
);
    localparam int TN_W   = $clog2(MAX_TAPS + 1);
    localparam int IDX_W  = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + ((MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 0);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(0);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAPN = pADDR_WIDTH'(20);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(128);

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT_IN, S_MAC, S_OUT} state_t;

    // Reduce the shifted accumulator to the output width (clamp or wrap).
    function automatic logic signed [DATA_W-1:0] reduce_out(input logic signed [ACC_W-1:0] v);
`ifdef FIR_SAT_EN
        if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
        else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        else                  return DATA_W'(v);
`else
        return DATA_W'(v);
`endif
    endfunction

    function automatic logic addr_is_tap(input logic [pADDR_WIDTH-1:0] a);
        logic [pADDR_WIDTH-1:0] off;
        off = a - TAP_BASE;
        return (a >= TAP_BASE) && (off[1:0] == 2'b00) && ((off >> 2) < pADDR_WIDTH'(MAX_TAPS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_tap_idx(input logic [pADDR_WIDTH-1:0] a);
        return IDX_W'((a - TAP_BASE) >> 2);
    endfunction

    function automatic logic [TN_W-1:0] clamp_taps(input logic [31:0] v);
        if (v == 32'd0)                 return TN_W'(1);
        else if (v > 32'(MAX_TAPS))     return TN_W'(MAX_TAPS);
        else                            return TN_W'(v);
    endfunction

    state_t state_q, state_d;

    logic                     ap_start, ap_done, ap_idle, tlast_err;
    logic [31:0]              data_length, len_eff, count_q;
    logic [TN_W-1:0]          tap_num, k_q;
    logic signed [COEF_W-1:0] taps [MAX_TAPS];
    logic signed [DATA_W-1:0] x    [MAX_TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_nxt;
    logic signed [PROD_W-1:0] prod;
    logic [IDX_W-1:0]         k_idx, aw_idx, ar_idx;
    logic                     aw_is_tap, ar_is_tap;

    logic wr_wait_q, wr_ack_q, rd_en_q;
    logic wr_fire, rd_fire, rd_ctrl;
    logic go, in_fire, mac_last, out_fire, last_sample, done_set, tlast_bad;
    logic [31:0] rd_val;

    assign awready   = wr_ack_q;
    assign wready    = wr_ack_q;
    assign arready   = rd_en_q && !rvalid;
    assign wr_fire   = awvalid && wvalid && !wr_wait_q;
    assign rd_fire   = arvalid && arready;
    assign rd_ctrl   = rd_fire && (araddr == ADDR_CTRL);
    assign aw_is_tap = addr_is_tap(awaddr);
    assign ar_is_tap = addr_is_tap(araddr);
    assign aw_idx    = addr_tap_idx(awaddr);
    assign ar_idx    = addr_tap_idx(araddr);
    assign k_idx     = k_q[IDX_W-1:0];

    assign len_eff     = (data_length == 32'd0) ? 32'd1 : data_length;
    assign last_sample = (count_q == len_eff);
    assign done_set    = out_fire && last_sample;
    assign tlast_bad   = in_fire && (ss_tlast != ((count_q + 32'd1) == len_eff));

    // State register.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // Next-state, stream handshakes and per-state event strobes.
    always_comb begin
        state_d   = state_q;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        go        = 1'b0;
        in_fire   = 1'b0;
        mac_last  = 1'b0;
        out_fire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    go      = 1'b1;
                    state_d = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    in_fire = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (k_q == tap_num - 1'b1) begin
                    mac_last = 1'b1;
                    state_d  = S_OUT;
                end
            end
            S_OUT: begin
                sm_tvalid = 1'b1;
                if (sm_tready) begin
                    out_fire = 1'b1;
                    state_d  = last_sample ? S_IDLE : S_WAIT_IN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shared multiply-accumulate for the current tap.
    always_comb begin
        prod    = PROD_W'(taps[k_idx]) * PROD_W'(x[k_idx]);
        acc_nxt = acc_q + ACC_W'(prod);
    end

    // Read-data mux; status bits fold in same-cycle sets so none is lost to clear-on-read.
    always_comb begin
        rd_val = '0;
        if (araddr == ADDR_CTRL)
            rd_val = {28'd0, tlast_err | tlast_bad, ap_idle | done_set, ap_done | done_set, ap_start};
        else if (araddr == ADDR_LEN)
            rd_val = data_length;
        else if (araddr == ADDR_TAPN)
            rd_val = 32'(tap_num);
        else if (ar_is_tap)
            rd_val = 32'(taps[ar_idx]);
    end

    // AXI-Lite channel handshakes and read-data holding.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_wait_q <= 1'b0;
            wr_ack_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
        end else begin
            rd_en_q  <= 1'b1;
            wr_ack_q <= wr_fire;
            if (wr_fire)                 wr_wait_q <= 1'b1;
            else if (!awvalid && !wvalid) wr_wait_q <= 1'b0;
            if (rd_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_val;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // Control/status and configuration registers, locked while a run is active.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ap_start    <= 1'b0;
            ap_done     <= 1'b0;
            ap_idle     <= 1'b1;
            tlast_err   <= 1'b0;
            data_length <= '0;
            tap_num     <= TN_W'(MAX_TAPS);
            for (int i = 0; i < MAX_TAPS; i++) taps[i] <= '0;
        end else begin
            if (rd_ctrl)       ap_done <= 1'b0;
            else if (done_set) ap_done <= 1'b1;
            if (rd_ctrl)        tlast_err <= 1'b0;
            else if (tlast_bad) tlast_err <= 1'b1;
            if (done_set) ap_idle <= 1'b0 | 1'b1;
            else if (go)  ap_idle <= 1'b0;
            if (wr_fire && ap_idle && (awaddr == ADDR_CTRL) && wdata[0]) ap_start <= 1'b1;
            else if (in_fire)                                            ap_start <= 1'b0;
            if (wr_fire && ap_idle) begin
                if (awaddr == ADDR_LEN)  data_length   <= wdata;
                if (awaddr == ADDR_TAPN) tap_num       <= clamp_taps(wdata);
                if (aw_is_tap)           taps[aw_idx]  <= wdata[COEF_W-1:0];
            end
        end
    end

    // Delay line, sample/tap counters and output holding registers.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            count_q  <= '0;
            k_q      <= '0;
            sm_tdata <= '0;
            sm_tlast <= 1'b0;
            for (int i = 0; i < MAX_TAPS; i++) x[i] <= '0;
        end else begin
            if (go) begin
                count_q <= '0;
                for (int i = 0; i < MAX_TAPS; i++) x[i] <= '0;
            end
            if (in_fire) begin
                for (int i = MAX_TAPS - 1; i > 0; i--) x[i] <= x[i-1];
                x[0]    <= ss_tdata;
                count_q <= count_q + 32'd1;
                k_q     <= '0;
            end
            if (state_q == S_MAC) k_q <= k_q + 1'b1;
            if (mac_last) begin
                sm_tdata <= reduce_out(acc_nxt >>> OUT_SHIFT);
                sm_tlast <= last_sample;
            end
            if (out_fire) sm_tlast <= 1'b0;
        end
    end

    // Accumulator: cleared per sample, so it needs no reset.
    always_ff @(posedge axis_clk) begin
        if (in_fire)               acc_q <= '0;
        else if (state_q == S_MAC) acc_q <= acc_nxt;
    end
endmodule

// File: tb/tb_fir_param_core.sv
// tb_fir_param_core: register table, scoreboarded stream runs and multi-cycle corner cases.
module tb_fir_param_core;
    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, arready, rvalid;
    logic [11:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0, rdata;
    logic        ss_tvalid = 1'b0, ss_tlast = 1'b0, ss_tready;
    logic signed [31:0] ss_tdata = '0, sm_tdata;
    logic        sm_tvalid, sm_tlast, sm_tready = 1'b1;

    fir_param_core dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct packed { logic [31:0] data; logic last; } exp_t;
    typedef struct { logic [11:0] addr; logic [31:0] wd; logic [31:0] rd_exp; } reg_vec_t;

    exp_t        exp_q[$];
    int          checks = 0, failures = 0, out_cnt = 0;
    logic [31:0] stim_d[16], exp_d[16];
    logic        exp_l[16];
    int          basic_exp[11] = '{1, 4, 10, 20, 35, 56, 84, 120, 165, 220, 286};
    reg_vec_t    rv[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=0x%08h required=0x%08h", name, got, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
        int t = 0;
        @(posedge axis_clk); #1;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
        @(negedge axis_clk);
        while (!(awready && wready) && t < 50) begin @(negedge axis_clk); t++; end
        if (!(awready && wready)) timeout_fail("axil_write");
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
        int t = 0;
        @(posedge axis_clk); #1;
        arvalid = 1'b1; araddr = a;
        @(negedge axis_clk);
        while (!arready && t < 50) begin @(negedge axis_clk); t++; end
        if (!arready) timeout_fail("axil_arready");
        @(posedge axis_clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        t = 0;
        @(negedge axis_clk);
        while (!rvalid && t < 50) begin @(negedge axis_clk); t++; end
        if (!rvalid) timeout_fail("axil_rvalid");
        d = rdata;
        @(posedge axis_clk); #1;
        rready = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] req);
        logic [31:0] v;
        axil_read(a, v);
        check(name, v, req);
    endtask

    task automatic send_stream(input int n, input int tlast_idx);
        for (int i = 0; i < n; i++) begin
            int t;
            exp_q.push_back('{data: exp_d[i], last: exp_l[i]});
            @(posedge axis_clk); #1;
            ss_tvalid = 1'b1; ss_tdata = stim_d[i]; ss_tlast = (i == tlast_idx);
            t = 0;
            @(negedge axis_clk);
            while (!ss_tready && t < 400) begin @(negedge axis_clk); t++; end
            if (!ss_tready) timeout_fail("ss_handshake");
            @(posedge axis_clk); #1;
            ss_tvalid = 1'b0; ss_tlast = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin @(negedge axis_clk); t++; end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s pending=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic setup_basic();
        for (int i = 0; i < 11; i++) axil_write(12'h080 + 12'(4 * i), 32'(i + 1));
        axil_write(12'h014, 32'd11);
        axil_write(12'h010, 32'd11);
        for (int i = 0; i < 11; i++) begin
            stim_d[i] = 32'(i + 1);
            exp_d[i]  = 32'(basic_exp[i]);
            exp_l[i]  = (i == 10);
        end
    endtask

    // Output monitor: handshake at the coming edge is decided by values held now.
    initial begin
        exp_t e;
        forever begin
            @(negedge axis_clk);
            if (axis_rst_n && sm_tvalid && sm_tready) begin
                out_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got=0x%08h required=none", sm_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (sm_tdata !== e.data || sm_tlast !== e.last) begin
                        failures++;
                        $display("FAIL stream_out#%0d got=0x%08h/last%0b required=0x%08h/last%0b",
                                 out_cnt, sm_tdata, sm_tlast, e.data, e.last);
                    end
                end
            end
        end
    end

    initial begin
        int tv;
        int taps_m[4];
        int data_m[6];
        longint s;

        rv[0]  = '{12'h014, 32'd0,        32'd1};
        rv[1]  = '{12'h014, 32'd40,       32'd16};
        rv[2]  = '{12'h014, 32'd16,       32'd16};
        rv[3]  = '{12'h014, 32'd7,        32'd7};
        rv[4]  = '{12'h010, 32'h1234,     32'h1234};
        rv[5]  = '{12'h080, 32'hFFFFFFF6, 32'hFFFFFFF6};
        rv[6]  = '{12'h0BC, 32'h55,       32'h55};
        rv[7]  = '{12'h0C0, 32'h66,       32'h0};
        rv[8]  = '{12'h004, 32'h77,       32'h0};
        rv[9]  = '{12'h082, 32'h88,       32'h0};
        rv[10] = '{12'h000, 32'h0,        32'h4};

        // Reset state
        #12;
        check("rst_ctl_outs", 32'({awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_sm_tdata", sm_tdata, 32'd0);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        read_check("rst_ctrl", 12'h000, 32'h4);
        read_check("rst_tap_num", 12'h014, 32'd16);
        read_check("rst_len", 12'h010, 32'd0);
        read_check("rst_tap0", 12'h080, 32'd0);

        // Register table
        for (int i = 0; i < 11; i++) begin
            axil_write(rv[i].addr, rv[i].wd);
            read_check($sformatf("reg_vec%0d", i), rv[i].addr, rv[i].rd_exp);
        end

        // Basic run
        setup_basic();
        axil_write(12'h000, 32'd1);
        send_stream(11, 10);
        wait_drain("basic_drain");
        read_check("basic_ctrl1", 12'h000, 32'h6);
        read_check("basic_ctrl2", 12'h000, 32'h4);

        // Backpressure on the third output
        axil_write(12'h000, 32'd1);
        fork
            send_stream(11, 10);
            begin
                int t = 0;
                while (out_cnt < 13 && t < 500) begin @(negedge axis_clk); t++; end
                @(posedge axis_clk); #1;
                sm_tready = 1'b0;
                t = 0;
                @(negedge axis_clk);
                while (!sm_tvalid && t < 100) begin @(negedge axis_clk); t++; end
                if (!sm_tvalid) timeout_fail("bp_wait_valid");
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge axis_clk);
                    check("bp_valid", 32'(sm_tvalid), 32'd1);
                    check("bp_data", sm_tdata, 32'd10);
                    check("bp_ss_tready", 32'(ss_tready), 32'd0);
                end
                @(posedge axis_clk); #1;
                sm_tready = 1'b1;
            end
        join
        wait_drain("bp_drain");
        read_check("bp_ctrl", 12'h000, 32'h6);

        // Busy lockout
        axil_write(12'h000, 32'd1);
        fork
            send_stream(11, 10);
            begin
                repeat (5) @(posedge axis_clk);
                axil_write(12'h080, 32'd99);
                axil_write(12'h014, 32'd3);
            end
        join
        wait_drain("lock_drain");
        read_check("lock_tap0", 12'h080, 32'd1);
        read_check("lock_tap_num", 12'h014, 32'd11);
        read_check("lock_ctrl", 12'h000, 32'h6);

        // Saturation / wrap
        axil_write(12'h080, 32'h7FFFFFFF);
        axil_write(12'h084, 32'h7FFFFFFF);
        axil_write(12'h014, 32'd2);
        axil_write(12'h010, 32'd2);
        stim_d[0] = 32'h7FFFFFFF; stim_d[1] = 32'h7FFFFFFF;
`ifdef FIR_SAT_EN
        exp_d[0] = 32'h7FFFFFFF; exp_d[1] = 32'h7FFFFFFF;
`else
        exp_d[0] = 32'h00000001; exp_d[1] = 32'h00000002;
`endif
        exp_l[0] = 1'b0; exp_l[1] = 1'b1;
        axil_write(12'h000, 32'd1);
        send_stream(2, 1);
        wait_drain("sat_drain");
        read_check("sat_ctrl", 12'h000, 32'h6);

        // tlast mismatch
        axil_write(12'h080, 32'd1);
        axil_write(12'h014, 32'd1);
        axil_write(12'h010, 32'd3);
        for (int i = 0; i < 3; i++) begin
            stim_d[i] = 32'(5 + i); exp_d[i] = 32'(5 + i); exp_l[i] = (i == 2);
        end
        axil_write(12'h000, 32'd1);
        send_stream(3, 1);
        wait_drain("tlast_drain");
        read_check("tlast_ctrl1", 12'h000, 32'hE);
        read_check("tlast_ctrl2", 12'h000, 32'h4);

        // Random taps/data against a reference convolution
        for (int k = 0; k < 4; k++) begin
            tv = int'($urandom_range(200)) - 100;
            taps_m[k] = tv;
            axil_write(12'h080 + 12'(4 * k), 32'(tv));
        end
        axil_write(12'h014, 32'd4);
        axil_write(12'h010, 32'd6);
        for (int i = 0; i < 6; i++) data_m[i] = int'($urandom_range(2000)) - 1000;
        for (int i = 0; i < 6; i++) begin
            s = 0;
            for (int k = 0; k < 4; k++)
                if (i - k >= 0) s += longint'(taps_m[k]) * longint'(data_m[i-k]);
            stim_d[i] = 32'(data_m[i]);
            exp_d[i]  = 32'(s);
            exp_l[i]  = (i == 5);
        end
        axil_write(12'h000, 32'd1);
        send_stream(6, 5);
        wait_drain("rand_drain");
        read_check("rand_ctrl", 12'h000, 32'h6);

        // Reset in the middle of the MAC for sample 4
        setup_basic();
        axil_write(12'h000, 32'd1);
        send_stream(4, -1);
        repeat (3) @(posedge axis_clk);
        #2 axis_rst_n = 1'b0;
        #1;
        check("mid_rst_ctl_outs", 32'({awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}), 32'd0);
        check("mid_rst_sm_tdata", sm_tdata, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        exp_q.delete();
        repeat (3) @(posedge axis_clk);
        #1 axis_rst_n = 1'b1;
        read_check("mid_rst_ctrl", 12'h000, 32'h4);
        read_check("mid_rst_tap0", 12'h080, 32'd0);
        repeat (20) @(negedge axis_clk);
        check("mid_rst_no_output", 32'(sm_tvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
